uart_cmd_sequencer: RTL and testbench

Host-side command queue sitting directly upstream of UART_TX_DATA on the 10 MHz UART clock. Accepts delay-table entries as fields (AWG id, port, 24-bit delay), packs each into the 64-bit AWG command word, buffers the words in a FIFO, and hands them one at a time to UART_TX_DATA over its data/valid/ready handshake. It replaces hand-driven valid/ready sequencing with a reusable block that guarantees one frame per entry, in order.

---
 rtl/uart_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Packs delay-table entries into 64-bit AWG command words, queues them in a
// FIFO and hands them one at a time to UART_TX_DATA over data/valid/ready.
// Optional inter-frame gap: define UART_CMD_GAP_EN (adds parameter GAP_CYC).
module uart_cmd_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter logic [31:0] HEADER  = 32'h02002000,
  parameter int unsigned TIMEOUT = 64
`ifdef UART_CMD_GAP_EN
  ,
  parameter int unsigned GAP_CYC = 20
`endif
) (
  input  logic        I_clk_10M,
  input  logic        I_rst_n,
  input  logic        I_wr_en,
  input  logic [3:0]  I_awg_id,
  input  logic [3:0]  I_port,
  input  logic [23:0] I_delay,
  output logic        O_full,
  output logic        O_empty,
  output logic [AW:0] O_level,
  output logic [63:0] O_data,
  output logic        O_data_valid,
  input  logic        I_tx_ready,
  output logic        O_busy,
  output logic [15:0] O_sent_cnt,
  output logic        O_overflow,
  output logic        O_err_timeout,
  input  logic        I_clr_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACC  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

`ifdef UART_CMD_GAP_EN
  localparam logic [1:0]  ST_GAP   = 2'd3;
  localparam int unsigned GW       = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;
  logic [GW-1:0] gap_cnt;
`endif

  logic [1:0]    state;
  logic [TW-1:0] acc_cnt;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   wr_word;
  logic          push;
  logic          pop;
  logic [AW:0]   level_next;

  assign wr_word = {HEADER, I_awg_id, I_port, I_delay};
  // full is the registered flag, so a push while full is dropped even if a
  // pop happens in the same cycle
  assign push    = I_wr_en && !O_full;
  assign pop     = (state == ST_IDLE) && !O_empty && I_tx_ready;
  assign O_busy  = (state != ST_IDLE);

  // next occupancy after this cycle's push and pop
  always_comb begin
    level_next = O_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // word storage; flushed by resetting the pointers, so no reset here
  always_ff @(posedge I_clk_10M) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  // FIFO pointers, registered status flags and sticky overflow
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      O_level    <= '0;
      O_full     <= 1'b0;
      O_empty    <= 1'b1;
      O_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      O_level <= level_next;
      O_full  <= (level_next == (AW+1)'(DEPTH));
      O_empty <= (level_next == '0);
      if (I_clr_err) O_overflow <= 1'b0;
      if (I_wr_en && O_full) O_overflow <= 1'b1;
    end
  end

  // frame issue / acceptance / completion sequencing
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= ST_IDLE;
      acc_cnt       <= '0;
      O_data        <= '0;
      O_data_valid  <= 1'b0;
      O_sent_cnt    <= '0;
      O_err_timeout <= 1'b0;
`ifdef UART_CMD_GAP_EN
      gap_cnt       <= '0;
`endif
    end else begin
      O_data_valid <= 1'b0;
      if (I_clr_err) O_err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            O_data       <= mem[rd_ptr];
            O_data_valid <= 1'b1;
            acc_cnt      <= '0;
            state        <= ST_WAIT_ACC;
          end
        end
        ST_WAIT_ACC: begin
          if (!I_tx_ready) begin
            state <= ST_WAIT_DONE;
          end else if (acc_cnt == TW'(TIMEOUT - 1)) begin
            O_err_timeout <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            acc_cnt <= acc_cnt + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (I_tx_ready) begin
            O_sent_cnt <= O_sent_cnt + 16'd1;
`ifdef UART_CMD_GAP_EN
            // gap is counted from the ready-rise cycle, so GAP holds
            // GAP_CYC-1 cycles and the IDLE issue cycle completes it
            if (GAP_CYC > 1) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef UART_CMD_GAP_EN
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_LAST)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: table-driven packing/order
// vectors plus hand-written sequences for overflow, push/pop while full,
// acceptance timeout, reset mid-frame and the inter-frame gap.
module tb_uart_cmd_sequencer;

  localparam int TXM_MODEL = 0;
  localparam int TXM_LOW   = 1;
  localparam int TXM_HIGH  = 2;
`ifdef UART_CMD_GAP_EN
  localparam int EXP_GAP = 20;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  port;
    logic [23:0] delay;
    logic [63:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  awg_id;
  logic [3:0]  port;
  logic [23:0] delay;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic [63:0] data;
  logic        data_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] sent_cnt;
  logic        overflow;
  logic        err_timeout;
  logic        clr_err;

  int          tx_mode;
  logic        m_ready;
  int          m_state;
  int          m_cnt;
  int          busy_len;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic        prev_v;
  logic [63:0] got_q[$];
  int          vcyc_q[$];
  int          rise_q[$];
  vec_t        vecs[6];

  assign tx_ready = (tx_mode == TXM_MODEL) ? m_ready : (tx_mode == TXM_HIGH);

  uart_cmd_sequencer dut (
    .I_clk_10M    (clk),
    .I_rst_n      (rst_n),
    .I_wr_en      (wr_en),
    .I_awg_id     (awg_id),
    .I_port       (port),
    .I_delay      (delay),
    .O_full       (full),
    .O_empty      (empty),
    .O_level      (level),
    .O_data       (data),
    .O_data_valid (data_valid),
    .I_tx_ready   (tx_ready),
    .O_busy       (busy),
    .O_sent_cnt   (sent_cnt),
    .O_overflow   (overflow),
    .O_err_timeout(err_timeout),
    .I_clr_err    (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [3:0]  id_n;
    logic [3:0]  port_n;
    logic [23:0] dly;
    id_n   = 4'(i);
    port_n = 4'(i % 4);
    dly    = 24'h100000 + 24'(i);
    return {32'h02002000, id_n, port_n, dly};
  endfunction

  // transmitter model: drops ready 3 cycles after valid, raises it busy_len later
  initial begin
    m_ready = 1'b1;
    m_state = 0;
    m_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_state = 0;
        m_ready = 1'b1;
      end else begin
        case (m_state)
          0: if (data_valid) begin m_state = 1; m_cnt = 3; end
          1: begin
            m_cnt--;
            if (m_cnt == 0) begin m_ready = 1'b0; m_cnt = busy_len; m_state = 2; end
          end
          default: begin
            m_cnt--;
            if (m_cnt == 0) begin m_ready = 1'b1; m_state = 0; rise_q.push_back(cyc); end
          end
        endcase
      end
    end
  end

  // valid-pulse monitor
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        chk("valid_single_cycle", prev_v, 0);
        chk("valid_only_entering_wait_acc", busy, 1);
        got_q.push_back(data);
        vcyc_q.push_back(cyc);
      end
      prev_v = data_valid;
    end
  end

  initial begin
    #(100 * 80000);
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    got_q.delete();
    vcyc_q.delete();
    rise_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] i_id, input logic [3:0] i_port, input logic [23:0] i_dly);
    awg_id = i_id;
    port   = i_port;
    delay  = i_dly;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic push_gen(input int i);
    push(4'(i), 4'(i % 4), 24'h100000 + 24'(i));
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (!(sent_cnt == 16'(n) && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_sent_in_budget", 64'(k < budget), 1);
    chk("sent_cnt", sent_cnt, 64'(n));
  endtask

  task automatic check_gen_frames(input int n);
    chk("frame_count", 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk("frame_word_order", got_q[i], exp_word(i));
    end
  endtask

  initial begin
    int push_cyc;
    int v;
    int k;
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{4'he, 4'h0, 24'h00000a, 64'h02002000_e000000a};
    vecs[1] = '{4'he, 4'h1, 24'h000014, 64'h02002000_e1000014};
    vecs[2] = '{4'he, 4'h2, 24'h00001e, 64'h02002000_e200001e};
    vecs[3] = '{4'he, 4'h3, 24'h000028, 64'h02002000_e3000028};
    vecs[4] = '{4'hf, 4'h3, 24'hffffff, 64'h02002000_f3ffffff};
    vecs[5] = '{4'h0, 4'h0, 24'h000000, 64'h02002000_00000000};
    awg_id = '0; port = '0; delay = '0;
    tx_mode  = TXM_MODEL;
    busy_len = 640;

    // reset state
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_flags", {overflow, err_timeout}, 0);

    // packing, order and latency
    push_cyc = cyc;
    for (int i = 0; i < 6; i++) push(vecs[i].id, vecs[i].port, vecs[i].delay);
    chk("level_after_pushes", level, 5);
    wait_sent(6, 8000);
    chk("vec_frame_count", 64'(got_q.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) chk("vec_word", got_q[i], vecs[i].exp);
    end
    if (vcyc_q.size() > 0) chk("push_to_valid_latency", 64'(vcyc_q[0] - push_cyc), 2);
    chk("drained_empty", empty, 1);
    chk("drained_level", level, 0);

    // 17 pushes with ready low
    busy_len = 8;
    tx_mode  = TXM_LOW;
    do_reset();
    for (int i = 0; i < 17; i++) push_gen(i);
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_not_empty", empty, 0);
    chk("ovf_no_issue_while_not_ready", 64'(got_q.size()), 0);
    tx_mode = TXM_MODEL;
    wait_sent(16, 2000);
    repeat (50) @(negedge clk);
    check_gen_frames(16);
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // push while full with same-cycle pop; clear in the same cycle loses
    busy_len = 4;
    tx_mode  = TXM_LOW;
    do_reset();
    for (int i = 0; i < 16; i++) push_gen(i);
    chk("pp_full_before", full, 1);
    tx_mode = TXM_HIGH;
    awg_id = 4'ha; port = 4'h2; delay = 24'habcdef;
    wr_en   = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    clr_err = 1'b0;
    chk("pp_level", level, 15);
    chk("pp_overflow_set_wins", overflow, 1);
    chk("pp_full_after", full, 0);
    chk("pp_valid", data_valid, 1);
    chk("pp_data", data, exp_word(0));
    tx_mode = TXM_MODEL;
    wait_sent(16, 3000);
    repeat (20) @(negedge clk);
    check_gen_frames(16);
    chk("pp_empty", empty, 1);

    // acceptance timeout
    tx_mode = TXM_HIGH;
    do_reset();
    push(vecs[1].id, vecs[1].port, vecs[1].delay);
    push(vecs[2].id, vecs[2].port, vecs[2].delay);
    k = 0;
    while (vcyc_q.size() == 0 && k < 20) begin @(negedge clk); k++; end
    chk("to_first_valid_seen", 64'(vcyc_q.size() > 0), 1);
    v = (vcyc_q.size() > 0) ? vcyc_q[0] : cyc;
    while (cyc < v + 63) @(negedge clk);
    chk("to_not_early", err_timeout, 0);
    chk("to_busy_waiting", busy, 1);
    @(negedge clk);
    chk("to_flag", err_timeout, 1);
    chk("to_back_idle", busy, 0);
    @(negedge clk);
    chk("to_next_valid", data_valid, 1);
    chk("to_next_word", data, vecs[2].exp);
    chk("to_not_counted", sent_cnt, 0);
    while (cyc < v + 140) @(negedge clk);
    chk("to_second_flag", err_timeout, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_cleared", err_timeout, 0);
    chk("to_no_retry", 64'(got_q.size()), 2);
    chk("to_empty", empty, 1);

    // asynchronous reset mid-frame
    busy_len = 640;
    tx_mode  = TXM_MODEL;
    do_reset();
    for (int i = 0; i < 6; i++) push(vecs[i].id, vecs[i].port, vecs[i].delay);
    push(4'h7, 4'h3, 24'h000777);
    k = 0;
    while (got_q.size() < 2 && k < 2000) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk("mr_level_before", level, 5);
    chk("mr_sent_before", sent_cnt, 1);
    chk("mr_in_wait_done", {busy, tx_ready}, 2'b10);
    #10;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_level", level, 0);
    chk("mr_empty", empty, 1);
    chk("mr_sent", sent_cnt, 0);
    chk("mr_data", data, 0);
    chk("mr_valid", data_valid, 0);
    repeat (3) @(negedge clk);
    got_q.delete();
    vcyc_q.delete();
    rise_q.delete();
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("mr_no_valid_after", 64'(got_q.size()), 0);
    chk("mr_still_empty", empty, 1);

    // inter-frame gap
    busy_len = 10;
    tx_mode  = TXM_MODEL;
    do_reset();
    push(vecs[0].id, vecs[0].port, vecs[0].delay);
    push(vecs[1].id, vecs[1].port, vecs[1].delay);
    wait_sent(2, 500);
    chk("gap_samples", 64'(vcyc_q.size() >= 2 && rise_q.size() >= 1), 1);
    if (vcyc_q.size() >= 2 && rise_q.size() >= 1)
      chk("gap_cycles", 64'(vcyc_q[1] - rise_q[0] - 1), 64'(EXP_GAP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
